neuron_controller: RTL and testbench
====================================

// Module: neuron_controller
// PURPOSE
//  Sequencer that drives one neuron MAC datapath through a full evaluation.
//  It clears the accumulator, then steps the input offset 0..N-1 with ld asserted.
//  It then pulses ready so the activation output is valid, captures result, and
//  presents it downstream on a valid/ack handshake. It sits between the layer
//  scheduler (start) and the next layer's input buffer (out_valid/out_ack).
// PARAMETERS
//  N   10  inputs per neuron (MAC iterations); N>=2
//  DW   8  data width of the activation result
// PORTS
//  clk        in   1              rising-edge clock; the only clock
//  rst        in   1              asynchronous, active-high reset
//  start      in   1              request one neuron evaluation (sampled in IDLE/HOLD)
//  hidden_in  in   1              layer type for this evaluation, sampled with start
//  result     in   DW             activation output from datapath
//  acc_rst    out  1              synchronous clear to datapath accumulator
//  ld         out  1              accumulator load enable
//  offset     out  $clog2(N)      input/weight select index
//  ready      out  1              activation enable to datapath
//  hidden     out  1              registered hidden_in, held for whole evaluation
//  busy       out  1              high from accepted start until out_valid rises
//  out_valid  out  1              out_data valid; held until out_ack
//  out_data   out  DW             captured neuron result
//  out_ack    in   1              downstream accepts out_data while out_valid=1
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE; all outputs 0, including offset, hidden and
//  out_data. Reset mid-evaluation aborts it; no partial result is ever presented.
//  All outputs are registered.
//  FSM states and transitions:
//  - IDLE:  if start, latch hidden<=hidden_in and go to CLEAR.
//  - CLEAR: 1 cycle; acc_rst=1, ld=0, offset=0; go to ACC.
//  - ACC:   ld=1 for exactly N cycles; offset=0,1,...,N-1 (one per cycle).
//           After offset==N-1, go to ACT; offset returns to 0 (no wrap past N-1).
//  - ACT:   1 cycle; ready=1, ld=0. On exit, out_data<=result; go to HOLD.
//  - HOLD:  out_valid=1, out_data stable. If out_ack, go to IDLE, or to CLEAR
//           if start is also high in that cycle (back-to-back, no idle bubble).
//  busy=1 in CLEAR, ACC and ACT; busy=0 in IDLE and HOLD.
//  start is ignored in CLEAR, ACC and ACT (no queuing).
//  start in HOLD without out_ack is ignored.
//  out_ack while out_valid=0 is ignored.
//  Latency, with start sampled at edge 0:
//  - acc_rst high in cycle 1.
//  - ld high in cycles 2..N+1.
//  - ready high in cycle N+2.
//  - out_valid high from cycle N+3.
//  Minimum period between back-to-back results: N+3 cycles.
//  hidden holds its value from CLEAR through HOLD; it updates only on an accepted start.
//  offset counter width is $clog2(N); it never exceeds N-1.
// TESTING
//  1 Reset: assert rst mid-cycle -> all outputs 0 immediately (async), state IDLE.
//  2 Single eval, N=10: start=1 one cycle -> acc_rst@1, ld@2..11 with
//    offset 0..9, ready@12, out_valid@13, out_data=result sampled @12 (e.g. 8'h5A).
//  3 Handshake: hold out_ack=0 for 5 cycles -> out_valid and out_data stable;
//    out_ack=1 -> out_valid=0 next cycle, busy=0.
//  4 Back-to-back: out_ack=1 with start=1 in HOLD -> acc_rst next cycle;
//    second out_valid exactly 13 cycles after the first.
//  5 Ignored start: pulse start while offset=4 -> sequence unchanged, single result.
//    hidden_in toggled mid-eval -> hidden unchanged.
//  6 Abort: rst during ACC at offset=6 -> ld=0, offset=0, out_valid never rises.
//    A new start afterwards runs a full N-cycle sequence.

Source files
------------

// File: rtl/neuron_controller.sv
// Sequencer for one neuron MAC datapath: clear, accumulate N inputs,
// activate, then hand the captured result downstream on valid/ack.
module neuron_controller #(
    parameter int N  = 10,
    parameter int DW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 hidden_in,
    input  logic [DW-1:0]        result,
    output logic                 acc_rst,
    output logic                 ld,
    output logic [$clog2(N)-1:0] offset,
    output logic                 ready,
    output logic                 hidden,
    output logic                 busy,
    output logic                 out_valid,
    output logic [DW-1:0]        out_data,
    input  logic                 out_ack
);

    localparam int OW = $clog2(N);
    localparam logic [OW-1:0] LAST = OW'(N - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACC,
        ACT,
        HOLD
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [OW-1:0] offset_n;
    logic          take;
    logic          capture;

    always_comb begin
        state_n  = state;
        offset_n = offset;
        take     = 1'b0;
        capture  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = CLEAR;
                    take    = 1'b1;
                end
            end
            CLEAR: begin
                state_n  = ACC;
                offset_n = '0;
            end
            ACC: begin
                if (offset == LAST) begin
                    state_n  = ACT;
                    offset_n = '0;
                end else begin
                    offset_n = offset + OW'(1);
                end
            end
            ACT: begin
                state_n = HOLD;
                capture = 1'b1;
            end
            HOLD: begin
                // ack together with start chains straight into the next run
                if (out_ack) begin
                    if (start) begin
                        state_n = CLEAR;
                        take    = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every one is a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            offset    <= '0;
            acc_rst   <= 1'b0;
            ld        <= 1'b0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            hidden    <= 1'b0;
        end else begin
            state     <= state_n;
            offset    <= offset_n;
            acc_rst   <= (state_n == CLEAR);
            ld        <= (state_n == ACC);
            ready     <= (state_n == ACT);
            busy      <= (state_n == CLEAR) || (state_n == ACC) ||
                         (state_n == ACT);
            out_valid <= (state_n == HOLD);
            if (capture) begin
                out_data <= result;
            end
            if (take) begin
                hidden <= hidden_in;
            end
        end
    end

endmodule

// File: tb/tb_neuron_controller.sv
// Bench for neuron_controller: directed vector table, hand-written
// corner sequences and randomized traffic against a timeline model.
module tb_neuron_controller;

    localparam int N  = 10;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          hidden_in;
    logic [DW-1:0] result;
    logic          out_ack;
    logic          acc_rst;
    logic          ld;
    logic [3:0]    offset;
    logic          ready;
    logic          hidden;
    logic          busy;
    logic          out_valid;
    logic [DW-1:0] out_data;

    neuron_controller #(.N(N), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .hidden_in(hidden_in),
        .result(result), .acc_rst(acc_rst), .ld(ld), .offset(offset),
        .ready(ready), .hidden(hidden), .busy(busy),
        .out_valid(out_valid), .out_data(out_data), .out_ack(out_ack)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: age = cycles since the accepted start (0 = no evaluation).
    int            age;
    bit            m_hold;
    logic [DW-1:0] m_data;
    bit            m_hidden;

    task automatic model_reset();
        age      = 0;
        m_hold   = 0;
        m_data   = '0;
        m_hidden = 0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else if (age > 0) begin
            if (age == N + 2) begin
                m_data = result;
                m_hold = 1;
                age    = 0;
            end else begin
                age++;
            end
        end else if (!m_hold || out_ack) begin
            m_hold = 0;
            if (start) begin
                age      = 1;
                m_hidden = hidden_in;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    task automatic check_model();
        bit in_ld;
        in_ld = (age >= 2) && (age <= N + 1);
        chk("acc_rst", 32'(acc_rst), 32'(age == 1));
        chk("ld", 32'(ld), 32'(in_ld));
        chk("offset", 32'(offset), in_ld ? 32'(age - 2) : 32'd0);
        chk("ready", 32'(ready), 32'(age == N + 2));
        chk("busy", 32'(busy), 32'(age > 0));
        chk("out_valid", 32'(out_valid), 32'(m_hold));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("hidden", 32'(hidden), 32'(m_hidden));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic          st;
        logic          hid;
        logic          ack;
        logic [DW-1:0] res;
        logic          e_acc_rst;
        logic          e_ld;
        logic [3:0]    e_off;
        logic          e_rdy;
        logic          e_busy;
        logic          e_vld;
        logic [DW-1:0] e_data;
        logic          e_hidden;
    } vec_t;

    vec_t tv[19];

    initial begin
        int cnt;

        for (int i = 0; i < 19; i++) begin
            tv[i] = '{st: 1'b0, hid: 1'(i % 2), ack: 1'b0, res: 8'h33,
                      e_acc_rst: 1'b0, e_ld: 1'b0, e_off: 4'd0,
                      e_rdy: 1'b0, e_busy: 1'b0, e_vld: 1'b0,
                      e_data: 8'h00, e_hidden: 1'b1};
        end
        tv[0].st = 1'b1;
        tv[0].hid = 1'b1;
        tv[0].e_acc_rst = 1'b1;
        tv[0].e_busy = 1'b1;
        for (int i = 1; i <= N; i++) begin
            tv[i].e_ld = 1'b1;
            tv[i].e_off = 4'(i - 1);
            tv[i].e_busy = 1'b1;
        end
        tv[3].ack = 1'b1;
        tv[6].st = 1'b1;
        tv[6].hid = 1'b0;
        tv[11].e_rdy = 1'b1;
        tv[11].e_busy = 1'b1;
        tv[12].res = 8'h5A;
        for (int i = 12; i < 19; i++) begin
            tv[i].e_data = 8'h5A;
            tv[i].e_vld = (i < 18);
        end
        for (int i = 13; i < 18; i++) tv[i].res = 8'hC3;
        tv[14].st = 1'b1;
        tv[18].ack = 1'b1;

        rst = 1'b1;
        start = 1'b0;
        hidden_in = 1'b0;
        result = '0;
        out_ack = 1'b0;
        model_reset();
        step();
        step();
        rst = 1'b0;
        check_model();

        for (int i = 0; i < 19; i++) begin
            start = tv[i].st;
            hidden_in = tv[i].hid;
            out_ack = tv[i].ack;
            result = tv[i].res;
            step();
            chk($sformatf("tv%0d.acc_rst", i), 32'(acc_rst),
                32'(tv[i].e_acc_rst));
            chk($sformatf("tv%0d.ld", i), 32'(ld), 32'(tv[i].e_ld));
            chk($sformatf("tv%0d.offset", i), 32'(offset),
                32'(tv[i].e_off));
            chk($sformatf("tv%0d.ready", i), 32'(ready), 32'(tv[i].e_rdy));
            chk($sformatf("tv%0d.busy", i), 32'(busy), 32'(tv[i].e_busy));
            chk($sformatf("tv%0d.out_valid", i), 32'(out_valid),
                32'(tv[i].e_vld));
            chk($sformatf("tv%0d.out_data", i), 32'(out_data),
                32'(tv[i].e_data));
            chk($sformatf("tv%0d.hidden", i), 32'(hidden),
                32'(tv[i].e_hidden));
        end
        start = 1'b0;
        out_ack = 1'b0;

        // back-to-back results
        result = 8'h77;
        start = 1'b1;
        step();
        start = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 50) begin
            step();
            check_model();
            cnt++;
        end
        chk("b2b_first_valid", 32'(out_valid), 32'd1);
        out_ack = 1'b1;
        start = 1'b1;
        result = 8'h21;
        step();
        check_model();
        chk("b2b_acc_rst", 32'(acc_rst), 32'd1);
        out_ack = 1'b0;
        start = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 40) begin
            step();
            check_model();
            cnt++;
        end
        chk("b2b_gap", 32'(cnt), 32'(N + 3));
        chk("b2b_data", 32'(out_data), 32'h21);
        out_ack = 1'b1;
        step();
        check_model();
        out_ack = 1'b0;

        // abort during accumulation at offset 6
        start = 1'b1;
        step();
        start = 1'b0;
        cnt = 0;
        while (!(ld && offset == 4'd6) && cnt < 30) begin
            step();
            cnt++;
        end
        chk("abort_reach_off6", 32'(offset), 32'd6);
        #2 rst = 1'b1;
        #1 model_reset();
        chk("abort_ld", 32'(ld), 32'd0);
        chk("abort_offset", 32'(offset), 32'd0);
        check_model();
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            cnt += int'(out_valid);
        end
        chk("abort_no_valid", 32'(cnt), 32'd0);
        start = 1'b1;
        hidden_in = 1'b1;
        result = 8'h9C;
        step();
        check_model();
        start = 1'b0;
        for (int i = 0; i < N + 4; i++) begin
            step();
            check_model();
        end
        out_ack = 1'b1;
        step();
        check_model();
        out_ack = 1'b0;

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 9) < 3);
            out_ack = ($urandom_range(0, 1) == 1);
            hidden_in = 1'($urandom);
            result = 8'($urandom);
            step();
            check_model();
        end
        rst = 1'b0;
        start = 1'b0;
        out_ack = 1'b1;
        for (int i = 0; i < N + 4; i++) step();
        out_ack = 1'b0;

        // asynchronous reset while a result is held
        start = 1'b1;
        hidden_in = 1'b1;
        result = 8'hA5;
        step();
        start = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 30) begin
            step();
            cnt++;
        end
        check_model();
        #2 rst = 1'b1;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_out_data", 32'(out_data), 32'd0);
        chk("async_hidden", 32'(hidden), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        model_reset();
        check_model();
        @(negedge clk);
        rst = 1'b0;
        step();
        check_model();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_bad);
        $finish;
    end

endmodule
